// File: rtl/sram_rv_pkg.sv
// Shared supply/threshold levels and level<->bit helpers for the SRAM macro model.
package sram_rv_pkg;

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;

    function automatic bit lvl2bit(input real lvl);
        return (lvl >= VTH);
    endfunction

    function automatic real bit2lvl(input bit b);
        return b ? VDD : VSS;
    endfunction

endpackage

// File: rtl/sram_rv_sense_col.sv
// One column's differential sense amplifier with its registered output level.
module sram_rv_sense_col
    import sram_rv_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  real  bl_i,
    input  real  blb_i,
    output real  preout_o
);

    real preout_q;
    real preout_d;
    real diff;

    // Resolve only a full-swing split; precharge or conflicts keep the last value.
    always_comb begin
        preout_d = preout_q;
        diff     = bl_i - blb_i;
        if (diff >= VTH) begin
            preout_d = VDD;
        end else if (diff <= -VTH) begin
            preout_d = VSS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preout_q <= VSS;
        end else begin
            preout_q <= preout_d;
        end
    end

    assign preout_o = preout_q;

endmodule

// File: rtl/sram_rv_macro.sv
// Real-level behavioural SRAM macro: write drivers, ROWS x COLS cell array,
// wired-discharge read bitlines and per-column registered sense amplifiers.
module sram_rv_macro
    import sram_rv_pkg::*;
#(
    parameter int unsigned ROWS = 2,
    parameter int unsigned COLS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  real  data_in [0:COLS-1],
    input  real  row_wr  [0:ROWS-1],
    input  real  row_rd  [0:ROWS-1],
    output real  preout  [0:COLS-1],
    output real  bl_rd   [0:COLS-1],
    output real  blb_rd  [0:COLS-1]
);

    real              bl_wr  [0:COLS-1];
    real              blb_wr [0:COLS-1];
    logic [COLS-1:0]  wr_bits;
    logic [ROWS-1:0]  wr_act;
    logic [ROWS-1:0]  rd_act;
    logic [COLS-1:0]  rd_zero;
    logic [COLS-1:0]  rd_one;
    logic [COLS-1:0]  cell_q [0:ROWS-1];
    logic [COLS-1:0]  cell_d [0:ROWS-1];

    // Column write drivers: full-swing complementary levels.
    always_comb begin
        wr_bits = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            bl_wr[c]   = bit2lvl(lvl2bit(data_in[c]));
            blb_wr[c]  = bit2lvl(!lvl2bit(data_in[c]));
            wr_bits[c] = (bl_wr[c] > blb_wr[c]);
        end
    end

    always_comb begin
        wr_act = '0;
        rd_act = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            wr_act[r] = lvl2bit(row_wr[r]);
            rd_act[r] = lvl2bit(row_rd[r]);
        end
    end

    // Every active write row takes the same driven data.
    always_comb begin
        for (int unsigned r = 0; r < ROWS; r++) begin
            cell_d[r] = cell_q[r];
            if (wr_act[r]) begin
                cell_d[r] = wr_bits;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                cell_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                cell_q[r] <= cell_d[r];
            end
        end
    end

    // Precharged bitlines, pulled low by any selected cell holding the opposite value.
    always_comb begin
        rd_zero = '0;
        rd_one  = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                if (rd_act[r]) begin
                    if (cell_q[r][c]) begin
                        rd_one[c] = 1'b1;
                    end else begin
                        rd_zero[c] = 1'b1;
                    end
                end
            end
            bl_rd[c]  = rd_zero[c] ? VSS : VDD;
            blb_rd[c] = rd_one[c]  ? VSS : VDD;
        end
    end

    for (genvar c = 0; c < int'(COLS); c++) begin : g_sense
        sram_rv_sense_col u_sense (
            .clk       (clk),
            .rst_n     (rst_n),
            .bl_i      (bl_rd[c]),
            .blb_i     (blb_rd[c]),
            .preout_o  (preout[c])
        );
    end

endmodule

// File: tb/tb_sram_rv_macro.sv
// Directed bench for sram_rv_macro with a bit-level reference model.
module tb_sram_rv_macro;

    localparam int ROWS = 2;
    localparam int COLS = 8;

    logic clk;
    logic rst_n;
    real  data_in [0:COLS-1];
    real  row_wr  [0:ROWS-1];
    real  row_rd  [0:ROWS-1];
    real  preout  [0:COLS-1];
    real  bl_rd   [0:COLS-1];
    real  blb_rd  [0:COLS-1];

    int   checks;
    int   errors;
    logic chk_en;

    // reference model state: stored bits and expected sensed levels
    bit   mem   [0:ROWS-1][0:COLS-1];
    real  pre_m [0:COLS-1];

    real  dv [0:COLS-1];
    real  ev [0:COLS-1];

    sram_rv_macro #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .row_wr  (row_wr),
        .row_rd  (row_rd),
        .preout  (preout),
        .bl_rd   (bl_rd),
        .blb_rd  (blb_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int col, input real got, input real exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s col %0d: got %f expected %f", nm, col, got, exp);
        end
    endtask

    // model: sense from the cells as they were before this edge, then write
    always @(posedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < COLS; c++) begin
                int zeros;
                int ones;
                zeros = 0;
                ones  = 0;
                for (int r = 0; r < ROWS; r++) begin
                    if (row_rd[r] >= 0.8) begin
                        if (mem[r][c]) ones++;
                        else zeros++;
                    end
                end
                if (ones > 0 && zeros == 0) pre_m[c] = 1.5;
                else if (zeros > 0 && ones == 0) pre_m[c] = 0.0;
            end
            for (int r = 0; r < ROWS; r++) begin
                if (row_wr[r] >= 0.8) begin
                    for (int c = 0; c < COLS; c++) mem[r][c] = (data_in[c] >= 0.8);
                end
            end
        end
    end

    always @(negedge rst_n) begin
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mem[r][c] = 1'b0;
        for (int c = 0; c < COLS; c++) pre_m[c] = 0.0;
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < COLS; c++) begin
                bit any0;
                bit any1;
                any0 = 1'b0;
                any1 = 1'b0;
                for (int r = 0; r < ROWS; r++) begin
                    if (row_rd[r] >= 0.8) begin
                        if (mem[r][c]) any1 = 1'b1;
                        else any0 = 1'b1;
                    end
                end
                chk("model_bl_rd", c, bl_rd[c], any0 ? 0.0 : 1.5);
                chk("model_blb_rd", c, blb_rd[c], any1 ? 0.0 : 1.5);
                chk("model_preout", c, preout[c], pre_m[c]);
            end
        end
    end

    task automatic set_dv(input logic [7:0] b);
        for (int c = 0; c < COLS; c++) dv[c] = b[c] ? 1.5 : 0.0;
    endtask

    task automatic set_ev(input logic [7:0] b);
        for (int c = 0; c < COLS; c++) ev[c] = b[c] ? 1.5 : 0.0;
    endtask

    task automatic apply(input real w0, input real w1, input real r0, input real r1);
        @(negedge clk);
        #1;
        for (int c = 0; c < COLS; c++) data_in[c] = dv[c];
        row_wr[0] = w0;
        row_wr[1] = w1;
        row_rd[0] = r0;
        row_rd[1] = r1;
    endtask

    task automatic check_pre(input string nm);
        @(posedge clk);
        #1;
        for (int c = 0; c < COLS; c++) chk(nm, c, preout[c], ev[c]);
    endtask

    task automatic check_bl_now(input string nm, input real lvl);
        #1;
        for (int c = 0; c < COLS; c++) begin
            chk({nm, "_bl"}, c, bl_rd[c], lvl);
            chk({nm, "_blb"}, c, blb_rd[c], lvl);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            row_wr[r] = 0.0;
            row_rd[r] = 0.0;
            for (int c = 0; c < COLS; c++) mem[r][c] = 1'b0;
        end
        for (int c = 0; c < COLS; c++) begin
            data_in[c] = 0.0;
            pre_m[c]   = 0.0;
        end
        set_dv(8'h00);
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        apply(0.0, 0.0, 0.0, 0.0);
        rst_n = 1'b1;

        // read after reset
        apply(0.0, 0.0, 1.5, 0.0);
        set_ev(8'h00);
        check_pre("reset_read_row0");

        // write row 0 with {1.5,0,1.5,0,1.5,1.5,0,0}
        set_dv(8'h35);
        apply(1.5, 0.0, 0.0, 0.0);
        set_dv(8'h00);
        apply(0.0, 0.0, 0.0, 1.5);
        set_ev(8'h00);
        check_pre("row1_unchanged");
        apply(0.0, 0.0, 1.5, 0.0);
        set_ev(8'h35);
        check_pre("row0_readback");

        // idle: precharged bitlines, preout holds
        apply(0.0, 0.0, 0.0, 0.0);
        check_bl_now("idle", 1.5);
        check_pre("idle_hold");

        // threshold decode
        dv[0] = 0.8; dv[1] = 0.79; dv[2] = 1.0; dv[3] = 0.5;
        dv[4] = 1.2; dv[5] = 0.0;  dv[6] = 0.8; dv[7] = 0.3;
        apply(0.0, 1.5, 0.0, 0.0);
        apply(0.0, 0.0, 0.0, 1.5);
        set_ev(8'h55);
        check_pre("threshold_read");
        set_dv(8'hFF);
        apply(0.0, 0.79, 0.0, 0.0);
        apply(0.0, 0.0, 0.0, 1.5);
        check_pre("wordline_0p79_no_write");

        // multi-row conflict: both bitlines low, preout holds 0x55
        set_dv(8'hFF);
        apply(1.5, 0.0, 0.0, 0.0);
        set_dv(8'h00);
        apply(0.0, 1.5, 0.0, 0.0);
        apply(0.0, 0.0, 1.5, 1.5);
        check_bl_now("conflict", 0.0);
        set_ev(8'h55);
        check_pre("conflict_hold");

        // multi-row, identical data
        set_dv(8'hA6);
        apply(1.5, 1.5, 0.0, 0.0);
        apply(0.0, 0.0, 1.5, 1.5);
        set_ev(8'hA6);
        check_pre("multirow_same");

        // same-cycle read/write on row 1: old data first
        set_dv(8'h00);
        apply(0.0, 1.5, 0.0, 0.0);
        set_dv(8'hFF);
        apply(0.0, 1.5, 0.0, 1.5);
        set_ev(8'h00);
        check_pre("rw_same_old");
        apply(0.0, 0.0, 0.0, 1.5);
        set_ev(8'hFF);
        check_pre("rw_same_new");

        // asynchronous reset mid-operation
        apply(0.0, 0.0, 0.0, 0.0);
        #2;
        rst_n = 1'b0;
        #1;
        set_ev(8'h00);
        for (int c = 0; c < COLS; c++) chk("async_reset_preout", c, preout[c], ev[c]);
        set_dv(8'hFF);
        apply(1.5, 1.5, 0.0, 0.0);
        @(posedge clk);
        apply(0.0, 0.0, 0.0, 0.0);
        rst_n = 1'b1;
        apply(0.0, 0.0, 1.5, 0.0);
        check_pre("post_reset_row0");
        apply(0.0, 0.0, 0.0, 1.5);
        check_pre("post_reset_row1");

        apply(0.0, 0.0, 0.0, 0.0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
